// File: rtl/apl_req_sched.sv
// apl_req_sched: round-robin OpenCAPI request scheduler with per-stream outstanding limits and stream flush.
module apl_req_sched #(
  parameter int nstrms    = 64,
  parameter int sid_width = $clog2(nstrms),
  parameter int max_out   = 256,
  parameter int cnt_width = $clog2(max_out+1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [nstrms-1:0]    i_req_v,
  output logic [nstrms-1:0]    i_req_r,
  output logic                 o_req_v,
  input  logic                 o_req_r,
  output logic [sid_width-1:0] o_req_sid,
  input  logic                 i_rsp_v,
  output logic                 i_rsp_r,
  input  logic [sid_width-1:0] i_rsp_sid,
  input  logic                 i_flush_v,
  output logic                 i_flush_r,
  input  logic [sid_width-1:0] i_flush_sid,
  output logic                 o_flush_v,
  input  logic                 o_flush_r,
  output logic [sid_width-1:0] o_flush_sid,
  output logic                 o_err
);
  typedef enum logic [1:0] {IDLE, DRAIN, NOTIFY} fst_t;
  localparam logic [cnt_width-1:0] lim0 = cnt_width'(max_out);
  localparam logic [cnt_width-1:0] lim1 = cnt_width'(max_out - 1);
  fst_t st_q;
  logic req_v_q, req_v_d, err_q, flush_v_q, flush_r_q;
  logic can_load, hs, any, underflow, drained;
  logic [sid_width-1:0] req_sid_q, req_sid_d, rr_q, rr_d, fsid_q, gnt_sid;
  logic [cnt_width-1:0] cnt_q [nstrms];
  logic [cnt_width-1:0] cnt_d [nstrms];
  logic [nstrms-1:0] elig, hi, pick, gnt;
  assign can_load  = !req_v_q || o_req_r;
  assign hs        = req_v_q && o_req_r;
  assign any       = can_load && |elig;
  assign i_req_r   = reset ? gnt : '0;
  assign o_req_v   = req_v_q;
  assign o_req_sid = req_sid_q;
  assign i_rsp_r   = 1'b1;
  assign i_flush_r = flush_r_q;
  assign o_flush_v = flush_v_q;
  assign o_flush_sid = fsid_q;
  assign o_err     = err_q;
  // a request sitting in the output register already counts against its stream's limit
  always_comb begin
    elig = '0;
    cnt_d = cnt_q;
    for (int s = 0; s < nstrms; s++) begin
      elig[s] = i_req_v[s] && !(st_q != IDLE && fsid_q == sid_width'(s)) &&
                cnt_q[s] < ((req_v_q && req_sid_q == sid_width'(s)) ? lim1 : lim0);
      cnt_d[s] = (hs && req_sid_q == sid_width'(s) && !(i_rsp_v && i_rsp_sid == sid_width'(s))) ? cnt_q[s] + cnt_width'(1) :
                 (i_rsp_v && i_rsp_sid == sid_width'(s) && !(hs && req_sid_q == sid_width'(s)) && cnt_q[s] != '0) ? cnt_q[s] - cnt_width'(1) :
                 cnt_q[s];
    end
  end
  always_comb begin
    hi = elig & ~((nstrms'(1) << rr_q) - nstrms'(1));
    pick = (|hi) ? hi : elig;
    gnt_sid = '0;
    for (int i = nstrms - 1; i >= 0; i--) gnt_sid = pick[i] ? sid_width'(i) : gnt_sid;
    gnt = any ? nstrms'(1) << gnt_sid : '0;
    req_v_d = can_load ? |elig : req_v_q;
    req_sid_d = any ? gnt_sid : req_sid_q;
    rr_d = !any ? rr_q : (gnt_sid == sid_width'(nstrms - 1)) ? '0 : gnt_sid + sid_width'(1);
    underflow = i_rsp_v && cnt_q[i_rsp_sid] == '0 && !(hs && req_sid_q == i_rsp_sid);
    drained = cnt_d[fsid_q] == '0 && !(req_v_d && req_sid_d == fsid_q);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_v_q <= 1'b0;
      req_sid_q <= '0;
      rr_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '{default: '0};
    end else begin
      req_v_q <= req_v_d;
      req_sid_q <= req_sid_d;
      rr_q <= rr_d;
      err_q <= err_q | underflow;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q <= IDLE;
      fsid_q <= '0;
      flush_v_q <= 1'b0;
      flush_r_q <= 1'b1;
    end else begin
      case (st_q)
        IDLE: if (i_flush_v) begin
          st_q <= DRAIN;
          fsid_q <= i_flush_sid;
          flush_r_q <= 1'b0;
        end
        DRAIN: if (drained) begin
          st_q <= NOTIFY;
          flush_v_q <= 1'b1;
        end
        NOTIFY: if (o_flush_r) begin
          st_q <= IDLE;
          flush_v_q <= 1'b0;
          flush_r_q <= 1'b1;
        end
        default: st_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apl_req_sched.sv
// tb_apl_req_sched: directed scenarios plus randomized traffic against a queue-free behavioural model.
module tb_apl_req_sched;
  localparam int N = 64, SW = 6, MAXO = 256;
  logic clk = 1'b0, reset = 1'b1;
  logic [N-1:0] i_req_v = '0, i_req_r;
  logic o_req_v, o_req_r = 1'b0;
  logic [SW-1:0] o_req_sid;
  logic i_rsp_v = 1'b0, i_rsp_r;
  logic [SW-1:0] i_rsp_sid = '0;
  logic i_flush_v = 1'b0, i_flush_r;
  logic [SW-1:0] i_flush_sid = '0;
  logic o_flush_v, o_flush_r = 1'b0;
  logic [SW-1:0] o_flush_sid;
  logic o_err;
  int n_tests = 0, n_fail = 0;
  int m_cnt [N];
  bit m_v, m_err;
  int m_sid, m_rr, m_fst, m_fsid;

  apl_req_sched dut (
    .clk(clk), .reset(reset),
    .i_req_v(i_req_v), .i_req_r(i_req_r),
    .o_req_v(o_req_v), .o_req_r(o_req_r), .o_req_sid(o_req_sid),
    .i_rsp_v(i_rsp_v), .i_rsp_r(i_rsp_r), .i_rsp_sid(i_rsp_sid),
    .i_flush_v(i_flush_v), .i_flush_r(i_flush_r), .i_flush_sid(i_flush_sid),
    .o_flush_v(o_flush_v), .o_flush_r(o_flush_r), .o_flush_sid(o_flush_sid),
    .o_err(o_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic m_init();
    for (int s = 0; s < N; s++) m_cnt[s] = 0;
    m_v = 0; m_err = 0; m_sid = 0; m_rr = 0; m_fst = 0; m_fsid = 0;
  endtask

  // first requesting stream at or after the rotating pointer whose issued+pending count is below the limit
  function automatic int exp_grant();
    if (m_v && !o_req_r) return -1;
    for (int i = 0; i < N; i++) begin
      int s;
      s = (m_rr + i) % N;
      if (i_req_v[s] && m_cnt[s] + ((m_v && m_sid == s) ? 1 : 0) < MAXO && !(m_fst != 0 && m_fsid == s))
        return s;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_onehot();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = exp_grant();
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic tick();
    int g, rs;
    bit hs;
    g = exp_grant();
    hs = m_v && o_req_r;
    rs = i_rsp_v ? int'(i_rsp_sid) : -1;
    @(posedge clk);
    if (rs >= 0 && !(hs && rs == m_sid)) begin
      if (m_cnt[rs] == 0) m_err = 1; else m_cnt[rs]--;
    end
    if (hs && rs != m_sid) m_cnt[m_sid]++;
    if (!m_v || o_req_r) begin
      m_v = (g >= 0);
      if (g >= 0) begin m_sid = g; m_rr = (g + 1) % N; end
    end
    case (m_fst)
      0: if (i_flush_v) begin m_fst = 1; m_fsid = int'(i_flush_sid); end
      1: if (m_cnt[m_fsid] == 0 && !(m_v && m_sid == m_fsid)) m_fst = 2;
      default: if (o_flush_r) m_fst = 0;
    endcase
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    i_req_v = '0; o_req_r = 1'b0; i_rsp_v = 1'b0; i_flush_v = 1'b0; o_flush_r = 1'b0;
    m_init();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0; i_req_v = '1; o_req_r = 1'b1; #1;
    n_tests++; if (o_req_v !== 1'b0) begin n_fail++; $display("FAIL reset_o_req_v: got %b want 0", o_req_v); end
    n_tests++; if (o_req_sid !== '0) begin n_fail++; $display("FAIL reset_o_req_sid: got %0d want 0", o_req_sid); end
    n_tests++; if (i_req_r !== '0) begin n_fail++; $display("FAIL reset_i_req_r: got %h want 0", i_req_r); end
    n_tests++; if (o_flush_v !== 1'b0 || o_flush_sid !== '0) begin n_fail++; $display("FAIL reset_flush: got v=%b sid=%0d want 0/0", o_flush_v, o_flush_sid); end
    n_tests++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL reset_o_err: got %b want 0", o_err); end
    do_reset(); #1;
    n_tests++; if (i_flush_r !== 1'b1 || i_rsp_r !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got flush_r=%b rsp_r=%b want 1/1", i_flush_r, i_rsp_r); end
  endtask

  task automatic test_round_robin();
    do_reset(); i_req_v = '1; o_req_r = 1'b1; #1;
    n_tests++; if (i_req_r !== 64'h1) begin n_fail++; $display("FAIL rr_first_grant: got %h want 1", i_req_r); end
    n_tests++; if (o_req_v !== 1'b0) begin n_fail++; $display("FAIL rr_early_valid: got %b want 0", o_req_v); end
    tick();
    for (int k = 0; k <= N; k++) begin
      #1;
      n_tests++;
      if (o_req_v !== 1'b1 || o_req_sid !== SW'(k % N)) begin
        n_fail++; $display("FAIL rr_seq[%0d]: got v=%b sid=%0d want v=1 sid=%0d", k, o_req_v, o_req_sid, k % N);
      end
      tick();
    end
  endtask

  task automatic test_saturate();
    int issued, more;
    do_reset(); i_req_v = N'(1) << 5; o_req_r = 1'b1; issued = 0;
    for (int c = 0; c < 300; c++) begin
      #1;
      if (o_req_v) issued++;
      n_tests++; if (i_req_r !== exp_onehot()) begin n_fail++; $display("FAIL sat_grant[%0d]: got %h want %h", c, i_req_r, exp_onehot()); end
      tick();
    end
    #1;
    n_tests++; if (issued != MAXO) begin n_fail++; $display("FAIL sat_count: got %0d want %0d", issued, MAXO); end
    n_tests++; if (i_req_r !== '0 || o_req_v !== 1'b0) begin n_fail++; $display("FAIL sat_masked: got r=%h v=%b want 0/0", i_req_r, o_req_v); end
    i_rsp_v = 1'b1; i_rsp_sid = 5;
    tick();
    i_rsp_v = 1'b0; more = 0;
    for (int c = 0; c < 10; c++) begin #1; if (o_req_v) more++; tick(); end
    n_tests++; if (more != 1) begin n_fail++; $display("FAIL sat_refill: got %0d want 1", more); end
  endtask

  task automatic test_stall();
    do_reset(); i_req_v = N'(1) << 3; o_req_r = 1'b0;
    tick();
    for (int c = 0; c < 10; c++) begin
      #1;
      n_tests++; if (o_req_v !== 1'b1 || o_req_sid !== SW'(3)) begin n_fail++; $display("FAIL stall_hold[%0d]: got v=%b sid=%0d want 1/3", c, o_req_v, o_req_sid); end
      n_tests++; if (i_req_r !== '0) begin n_fail++; $display("FAIL stall_no_grant[%0d]: got %h want 0", c, i_req_r); end
      tick();
    end
    i_req_v = '0; o_req_r = 1'b1;
    tick();
    o_req_r = 1'b0; i_flush_v = 1'b1; i_flush_sid = 3;
    tick();
    i_flush_v = 1'b0; #1;
    n_tests++; if (o_flush_v !== 1'b0) begin n_fail++; $display("FAIL stall_cnt_drain: got %b want 0", o_flush_v); end
    i_rsp_v = 1'b1; i_rsp_sid = 3;
    tick();
    i_rsp_v = 1'b0; #1;
    n_tests++; if (o_flush_v !== 1'b1) begin n_fail++; $display("FAIL stall_cnt_one: got %b want 1", o_flush_v); end
    o_flush_r = 1'b1; tick(); o_flush_r = 1'b0;
  endtask

  task automatic test_inc_dec();
    do_reset(); o_req_r = 1'b1; i_req_v = N'(1) << 7;
    for (int c = 0; c < 20 && !(m_cnt[7] == 4 && m_v); c++) tick();
    i_req_v = '0; i_rsp_v = 1'b1; i_rsp_sid = 7;
    tick();
    i_rsp_v = 1'b0; #1;
    n_tests++; if (o_err !== 1'b0 || o_req_v !== 1'b0) begin n_fail++; $display("FAIL incdec_quiet: got err=%b v=%b want 0/0", o_err, o_req_v); end
    i_flush_v = 1'b1; i_flush_sid = 7;
    tick();
    i_flush_v = 1'b0;
    for (int r = 0; r < 4; r++) begin
      #1;
      n_tests++; if (o_flush_v !== 1'b0 || i_flush_r !== 1'b0) begin n_fail++; $display("FAIL incdec_drain[%0d]: got v=%b r=%b want 0/0", r, o_flush_v, i_flush_r); end
      i_rsp_v = 1'b1; i_rsp_sid = 7;
      tick();
      i_rsp_v = 1'b0;
    end
    #1;
    n_tests++; if (o_flush_v !== 1'b1 || o_flush_sid !== SW'(7)) begin n_fail++; $display("FAIL incdec_cnt4: got v=%b sid=%0d want 1/7", o_flush_v, o_flush_sid); end
    o_flush_r = 1'b1; tick(); o_flush_r = 1'b0; #1;
    n_tests++; if (i_flush_r !== 1'b1 || o_flush_v !== 1'b0) begin n_fail++; $display("FAIL incdec_idle: got r=%b v=%b want 1/0", i_flush_r, o_flush_v); end
    i_rsp_v = 1'b1; i_rsp_sid = 7;
    tick();
    i_rsp_v = 1'b0; #1;
    n_tests++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL underflow_err: got %b want 1", o_err); end
    i_flush_v = 1'b1; i_flush_sid = 7;
    tick();
    i_flush_v = 1'b0; #1;
    n_tests++; if (o_flush_v !== 1'b0) begin n_fail++; $display("FAIL empty_drain_cycle: got %b want 0", o_flush_v); end
    tick(); #1;
    n_tests++; if (o_flush_v !== 1'b1) begin n_fail++; $display("FAIL empty_notify: got %b want 1", o_flush_v); end
    o_flush_r = 1'b1; tick(); o_flush_r = 1'b0; #1;
    n_tests++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", o_err); end
  endtask

  task automatic test_flush();
    do_reset(); o_req_r = 1'b1;
    for (int c = 0; c < 20; c++) begin
      i_req_v = (m_cnt[1] + ((m_v && m_sid == 1) ? 1 : 0) < 3) ? N'(2) : '0;
      tick();
    end
    i_req_v = N'(4); i_flush_v = 1'b1; i_flush_sid = 1;
    tick();
    i_flush_v = 1'b0; i_req_v = N'(6);
    for (int c = 0; c < 6; c++) begin
      #1;
      n_tests++; if (o_req_v !== 1'b1 || o_req_sid === SW'(1) || i_req_r[1] !== 1'b0) begin n_fail++; $display("FAIL flush_mask[%0d]: got v=%b sid=%0d r=%h want v=1 sid!=1", c, o_req_v, o_req_sid, i_req_r); end
      tick();
    end
    for (int r = 0; r < 3; r++) begin
      #1;
      n_tests++; if (o_flush_v !== 1'b0 || i_flush_r !== 1'b0) begin n_fail++; $display("FAIL flush_wait[%0d]: got v=%b r=%b want 0/0", r, o_flush_v, i_flush_r); end
      i_rsp_v = 1'b1; i_rsp_sid = 1;
      tick();
      i_rsp_v = 1'b0;
    end
    #1;
    n_tests++; if (o_flush_v !== 1'b1 || o_flush_sid !== SW'(1)) begin n_fail++; $display("FAIL flush_notify: got v=%b sid=%0d want 1/1", o_flush_v, o_flush_sid); end
    for (int c = 0; c < 3; c++) begin
      tick(); #1;
      n_tests++; if (o_flush_v !== 1'b1 || i_flush_r !== 1'b0 || (o_req_v && o_req_sid == SW'(1))) begin n_fail++; $display("FAIL flush_hold[%0d]: got v=%b r=%b sid=%0d want 1/0 sid!=1", c, o_flush_v, i_flush_r, o_req_sid); end
    end
    o_flush_r = 1'b1; tick(); o_flush_r = 1'b0; #1;
    n_tests++; if (i_flush_r !== 1'b1 || o_flush_v !== 1'b0) begin n_fail++; $display("FAIL flush_done: got r=%b v=%b want 1/0", i_flush_r, o_flush_v); end
  endtask

  task automatic test_reset_mid();
    do_reset(); o_req_r = 1'b1; i_rsp_v = 1'b1; i_rsp_sid = 9;
    tick();
    i_rsp_v = 1'b0; i_req_v = N'(2);
    tick(); tick(); tick();
    i_req_v = '1; i_flush_v = 1'b1; i_flush_sid = 1;
    tick();
    i_flush_v = 1'b0;
    tick(); #1;
    n_tests++; if (o_err !== 1'b1 || o_req_v !== 1'b1 || i_flush_r !== 1'b0) begin n_fail++; $display("FAIL mid_pre: got err=%b v=%b fr=%b want 1/1/0", o_err, o_req_v, i_flush_r); end
    #1 reset = 1'b0; #1;
    n_tests++; if (o_req_v !== 1'b0 || o_req_sid !== '0 || i_req_r !== '0) begin n_fail++; $display("FAIL mid_req: got v=%b sid=%0d r=%h want 0/0/0", o_req_v, o_req_sid, i_req_r); end
    n_tests++; if (o_flush_v !== 1'b0 || o_flush_sid !== '0 || o_err !== 1'b0) begin n_fail++; $display("FAIL mid_flush: got v=%b sid=%0d err=%b want 0/0/0", o_flush_v, o_flush_sid, o_err); end
    m_init();
    @(negedge clk);
    reset = 1'b1; #1;
    n_tests++; if (i_req_r !== 64'h1 || i_flush_r !== 1'b1 || i_rsp_r !== 1'b1) begin n_fail++; $display("FAIL mid_release: got r=%h fr=%b rr=%b want 1/1/1", i_req_r, i_flush_r, i_rsp_r); end
    tick(); #1;
    n_tests++; if (o_req_v !== 1'b1 || o_req_sid !== '0) begin n_fail++; $display("FAIL mid_first: got v=%b sid=%0d want 1/0", o_req_v, o_req_sid); end
    tick(); #1;
    n_tests++; if (o_req_sid !== SW'(1) || o_flush_v !== 1'b0) begin n_fail++; $display("FAIL mid_second: got sid=%0d fv=%b want 1/0", o_req_sid, o_flush_v); end
  endtask

  task automatic test_random();
    int s;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      i_req_v = {56'b0, 8'($urandom)};
      o_req_r = ($urandom_range(0, 3) != 0);
      s = $urandom_range(0, 7);
      i_rsp_sid = SW'(s);
      i_rsp_v = (m_cnt[s] > 0) && ($urandom_range(0, 2) != 0);
      i_flush_v = ($urandom_range(0, 15) == 0);
      i_flush_sid = SW'($urandom_range(0, 7));
      o_flush_r = $urandom_range(0, 1) != 0;
      #1;
      n_tests++; if (i_req_r !== exp_onehot()) begin n_fail++; $display("FAIL rnd_grant[%0d]: got %h want %h", c, i_req_r, exp_onehot()); end
      n_tests++; if (o_req_v !== m_v || (m_v && o_req_sid !== SW'(m_sid))) begin n_fail++; $display("FAIL rnd_out[%0d]: got v=%b sid=%0d want v=%b sid=%0d", c, o_req_v, o_req_sid, m_v, m_sid); end
      n_tests++; if (o_flush_v !== (m_fst == 2) || i_flush_r !== (m_fst == 0) || (m_fst == 2 && o_flush_sid !== SW'(m_fsid))) begin n_fail++; $display("FAIL rnd_flush[%0d]: got v=%b r=%b sid=%0d want state %0d sid=%0d", c, o_flush_v, i_flush_r, o_flush_sid, m_fst, m_fsid); end
      n_tests++; if (o_err !== m_err) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b want %b", c, o_err, m_err); end
      tick();
    end
  endtask

  initial begin
    m_init();
    test_reset();
    test_round_robin();
    test_saturate();
    test_stall();
    test_inc_dec();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
